// File: rtl/fetch_inst_queue_if.sv
// Shared fetch-side types and the handshake bundle between fetch, the I-cache
// response path, the instruction queue and decode.
package fetch_inst_queue_pkg;
    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
        logic       bd;
        virt_t      badvaddr;
        logic       tlb_refill;
    } exception_t;

    typedef struct packed {
        logic        valid;
        virt_t       pc;
        logic [31:0] inst;
        exception_t  exception;
    } fs_to_ds_bus_t;

    typedef struct packed {
        logic flush;
    } pipeline_flush_t;
endpackage

interface fetch_inst_queue_if #(parameter int DEPTH = 4);
    import fetch_inst_queue_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            icache_req_fire;
    logic            icache_resp_valid;
    virt_t           icache_resp_pc;
    logic [31:0]     icache_resp_inst;
    exception_t      icache_resp_exception;
    logic            fq_req_allow;
    logic            ds_allowin;
    fs_to_ds_bus_t   fs_to_ds_bus;
    logic            bpu_flush;
    pipeline_flush_t pipeline_flush;
    logic [CW-1:0]   fq_count;

    modport master (
        output icache_req_fire, icache_resp_valid, icache_resp_pc, icache_resp_inst,
               icache_resp_exception, ds_allowin, bpu_flush, pipeline_flush,
        input  fq_req_allow, fs_to_ds_bus, fq_count
    );

    modport slave (
        input  icache_req_fire, icache_resp_valid, icache_resp_pc, icache_resp_inst,
               icache_resp_exception, ds_allowin, bpu_flush, pipeline_flush,
        output fq_req_allow, fs_to_ds_bus, fq_count
    );
endinterface

// File: rtl/fetch_inst_queue.sv
// IF->ID instruction queue: reserves a slot per outstanding I-cache request,
// drops wrong-path responses after flushes and can retain a delay-slot head.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    fetch_inst_queue_if.slave  fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outst, discard, outst_nxt;
    logic [CW:0]   reserved;

    virt_t       mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    exception_t  mem_exc  [DEPTH];

    logic head_valid, pop, push, keep_bd, any_flush, wr_en;

    assign head_valid = (count != '0);
    assign pop        = head_valid && fq.ds_allowin;
    assign push       = fq.icache_resp_valid && (discard == '0);
    assign keep_bd    = head_valid && !pop && mem_exc[rd_ptr].bd;
    assign any_flush  = fq.pipeline_flush.flush || fq.bpu_flush;
    assign wr_en      = push && !any_flush;

    always_comb begin
        outst_nxt = outst;
        case ({fq.icache_req_fire, fq.icache_resp_valid})
            2'b10:   outst_nxt = outst + CW'(1);
            2'b01:   outst_nxt = outst - CW'(1);
            default: outst_nxt = outst;
        endcase
    end

    // Dead responses already counted in discard must not hold a reservation.
    assign reserved        = {1'b0, count} + {1'b0, outst} - {1'b0, discard};
    assign fq.fq_req_allow = (reserved < DEPTH_W);

    assign fq.fq_count           = count;
    assign fq.fs_to_ds_bus.valid = head_valid;
    assign fq.fs_to_ds_bus.pc    = mem_pc[rd_ptr];
    assign fq.fs_to_ds_bus.inst  = mem_inst[rd_ptr];
    assign fq.fs_to_ds_bus.exception = mem_exc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            outst   <= '0;
            discard <= '0;
        end else begin
            outst <= outst_nxt;
            if (fq.pipeline_flush.flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                discard <= outst_nxt;
            end else if (fq.bpu_flush) begin
                discard <= outst_nxt;
                if (keep_bd) begin
                    count  <= CW'(1);
                    wr_ptr <= rd_ptr + AW'(1);
                end else begin
                    count  <= '0;
                    rd_ptr <= rd_ptr + AW'(pop);
                    wr_ptr <= rd_ptr + AW'(pop);
                end
            end else begin
                if (fq.icache_resp_valid && (discard != '0))
                    discard <= discard - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= fq.icache_resp_pc;
            mem_inst[wr_ptr] <= fq.icache_resp_inst;
            mem_exc[wr_ptr]  <= fq.icache_resp_exception;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !any_flush && (count == CW'(DEPTH))));

endmodule
